time_set_controller: RTL and testbench

//   Timekeeping and time-setting sequencer for the digital clock.

---
 rtl/time_set_controller.sv | 99 +++++++++
 tb/tb_time_set_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// Digital clock timekeeping core: runs HH:MM:SS on a 1 Hz tick, or freezes it
// while the MODE button walks through hour/minute/second edit fields.
module time_set_controller #(
    parameter int HOUR_MAX = 23,
    parameter int MIN_MAX  = 59
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       tick,
    input  logic       mode_click,
    input  logic       inc_click,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       blink
);

    // state    | meaning
    // ST_RUN   | counters advance on tick, inc_click ignored
    // ST_SET_H | time frozen, inc_click steps hours
    // ST_SET_M | time frozen, inc_click steps minutes
    // ST_SET_S | time frozen, inc_click steps seconds
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_SET_H = 2'd1;
    localparam logic [1:0] ST_SET_M = 2'd2;
    localparam logic [1:0] ST_SET_S = 2'd3;

    localparam logic [4:0] H_LAST = 5'(HOUR_MAX);
    localparam logic [5:0] M_LAST = 6'(MIN_MAX);

    logic [4:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic [1:0] mode_q, mode_d;
    logic       blink_q, blink_d;

    logic       hr_wrap, min_wrap, sec_wrap;
    logic [4:0] hr_inc;
    logic [5:0] min_inc, sec_inc;

    always_comb begin
        // ">=" rather than "==" so an out-of-range field recovers to 0
        hr_wrap  = (hours_q >= H_LAST);
        min_wrap = (minutes_q >= M_LAST);
        sec_wrap = (seconds_q >= M_LAST);
        hr_inc   = hr_wrap  ? 5'd0 : hours_q + 5'd1;
        min_inc  = min_wrap ? 6'd0 : minutes_q + 6'd1;
        sec_inc  = sec_wrap ? 6'd0 : seconds_q + 6'd1;

        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        mode_d    = mode_click ? mode_q + 2'd1 : mode_q;

        case (mode_q)
            ST_RUN: begin
                if (tick) begin
                    seconds_d = sec_inc;
                    if (sec_wrap) begin
                        minutes_d = min_inc;
                        if (min_wrap) hours_d = hr_inc;
                    end
                end
            end
            ST_SET_H: if (inc_click) hours_d   = hr_inc;
            ST_SET_M: if (inc_click) minutes_d = min_inc;
            ST_SET_S: if (inc_click) seconds_d = sec_inc;
            default: ;
        endcase

        if (mode_click || mode_q == ST_RUN) blink_d = 1'b0;
        else if (tick)                      blink_d = ~blink_q;
        else                                blink_d = blink_q;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            mode_q    <= ST_RUN;
            blink_q   <= 1'b0;
        end else begin
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            mode_q    <= mode_d;
            blink_q   <= blink_d;
        end
    end

    assign hours   = hours_q;
    assign minutes = minutes_q;
    assign seconds = seconds_q;
    assign mode    = mode_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed scenarios plus random clicks/ticks,
// checked against a time-of-day model kept as total seconds.
module tb_time_set_controller;

    localparam int HM = 23;
    localparam int MM = 59;
    localparam int DAY = (HM + 1) * (MM + 1) * (MM + 1);

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       mode_click = 1'b0;
    logic       inc_click = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;

    int total = 0;
    int bad = 0;

    int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_blink = 0;

    time_set_controller #(.HOUR_MAX(HM), .MIN_MAX(MM)) dut (
        .clock(clock), .rst(rst), .tick(tick),
        .mode_click(mode_click), .inc_click(inc_click),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .mode(mode), .blink(blink)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference: RUN advances a seconds-of-day count; SET modes step one field modulo its range.
    task automatic model(input bit r, input bit t, input bit mc, input bit ic);
        int tod;
        if (r) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 0;
            return;
        end
        if (m_mode == 0 && t) begin
            tod = (m_h * (MM + 1) * (MM + 1) + m_m * (MM + 1) + m_s + 1) % DAY;
            m_s = tod % (MM + 1);
            m_m = (tod / (MM + 1)) % (MM + 1);
            m_h = tod / ((MM + 1) * (MM + 1));
        end
        if (ic) begin
            if (m_mode == 1) m_h = (m_h + 1) % (HM + 1);
            if (m_mode == 2) m_m = (m_m + 1) % (MM + 1);
            if (m_mode == 3) m_s = (m_s + 1) % (MM + 1);
        end
        if (mc || m_mode == 0) m_blink = 0;
        else if (t)            m_blink = 1 - m_blink;
        if (mc) m_mode = (m_mode + 1) % 4;
    endtask

    task automatic step(input bit r, input bit t, input bit mc, input bit ic);
        rst = r; tick = t; mode_click = mc; inc_click = ic;
        @(posedge clock);
        model(r, t, mc, ic);
        #1;
        chk("hours", int'(hours), m_h);
        chk("minutes", int'(minutes), m_m);
        chk("seconds", int'(seconds), m_s);
        chk("mode", int'(mode), m_mode);
        chk("blink", int'(blink), m_blink);
        rst = 0; tick = 0; mode_click = 0; inc_click = 0;
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    initial begin
        // 1: reset, idle, five ticks
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t1_rst_time", int'({hours, minutes, seconds}), 0);
        chk("t1_rst_mode", int'(mode), 0);
        chk("t1_rst_blink", int'(blink), 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        chk("t1_sec5", int'(seconds), 5);

        // 2: preload 23:59:59, one tick wraps the whole day
        step(1, 0, 0, 0);
        step(0, 0, 1, 0); incs(23);
        step(0, 0, 1, 0); incs(59);
        step(0, 0, 1, 0); incs(59);
        step(0, 0, 1, 0);
        chk("t2_pre_h", int'(hours), 23);
        chk("t2_pre_s", int'(seconds), 59);
        step(0, 1, 0, 0);
        chk("t2_wrap", int'({hours, minutes, seconds}), 0);

        // 3: minutes edit wrap does not carry (time is 01:59:07 beforehand)
        step(1, 0, 0, 0);
        step(0, 0, 1, 0); incs(1);
        step(0, 0, 1, 0); incs(59);
        step(0, 0, 1, 0); incs(7);
        step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
        chk("t3_mode", int'(mode), 2);
        step(0, 0, 0, 1);
        chk("t3_min", int'(minutes), 0);
        chk("t3_hr", int'(hours), 1);
        chk("t3_sec", int'(seconds), 7);

        // 4: simultaneous mode+inc in SET_H
        step(1, 0, 0, 0);
        step(0, 0, 1, 0); incs(4);
        step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        chk("t4_hr", int'(hours), 5);
        chk("t4_mode", int'(mode), 2);
        chk("t4_blink", int'(blink), 0);

        // 5: blink toggles on ticks in SET_H, time frozen
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0); chk("t5_b1", int'(blink), 1);
        step(0, 1, 0, 0); chk("t5_b2", int'(blink), 0);
        step(0, 1, 0, 0); chk("t5_b3", int'(blink), 1);
        chk("t5_frozen", int'({hours, minutes, seconds}), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        chk("t5_mode", int'(mode), 0);
        chk("t5_blink", int'(blink), 0);

        // 6: reset mid-edit at 12:34:56 in SET_S
        step(0, 0, 1, 0); incs(12);
        step(0, 0, 1, 0); incs(34);
        step(0, 0, 1, 0); incs(56);
        chk("t6_pre", int'(seconds), 56);
        step(1, 1, 1, 1);
        chk("t6_time", int'({hours, minutes, seconds}), 0);
        chk("t6_mode", int'(mode), 0);
        chk("t6_blink", int'(blink), 0);

        // Edge-case pairs from RUN and SET_S
        step(0, 1, 1, 0);
        chk("run_tick_mode_sec", int'(seconds), 1);
        chk("run_tick_mode_mode", int'(mode), 1);
        step(0, 0, 1, 0); step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        chk("sets_tick_mode_sec", int'(seconds), 1);
        chk("sets_tick_mode_mode", int'(mode), 0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
